// File: rtl/uart_img_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_img_pkg                                              |
// | Brief    : Shared state encodings and constants for uart_img_loader  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package uart_img_pkg;

  // UART receive state machine
  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

  // Image framing state machine; F_HDR0/F_HDR1 only reachable with IMG_HDR_EN
  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_HDR0 = 2'd1,
    F_HDR1 = 2'd2,
    F_LOAD = 2'd3
  } frame_state_t;

  localparam logic [7:0] HDR0               = 8'h55;
  localparam logic [7:0] HDR1               = 8'hAA;
  localparam int         IMG_PIXELS_DEFAULT = 784;

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_rx_byte                                              |
// | Brief    : 2-FF rx synchronizer + 8N1 receiver. Emits one-cycle      |
// |            byte_valid on a good stop bit, stop_err on a bad one.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_rx_byte
  import uart_img_pkg::*;
#(
  parameter int BIT_CYC  = 416,
  parameter int HALF_CYC = 208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       byte_valid,
  output logic       stop_err
);

  localparam int CNT_W = $clog2(BIT_CYC + 1);

  logic [1:0]       r_sync;
  logic             r_prev;
  rx_state_t        r_state;
  rx_state_t        w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             w_rx;
  logic             w_fall;
  logic             w_half;
  logic             w_full;

  assign w_rx   = r_sync[1];
  assign w_fall = r_prev & ~w_rx;
  assign w_half = (r_cnt == CNT_W'(HALF_CYC - 1));
  assign w_full = (r_cnt == CNT_W'(BIT_CYC - 1));

  // Synchronize the asynchronous line and keep one delayed copy for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], rx};
      r_prev <= r_sync[1];
    end
  end

  // RX state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= w_next;
  end

  // RX next-state: start bit re-checked at mid-bit to reject glitches
  always_comb begin
    w_next = r_state;
    case (r_state)
      R_IDLE:  if (w_fall) w_next = R_START;
      R_START: if (w_half) w_next = w_rx ? R_IDLE : R_DATA;
      R_DATA:  if (w_full && (r_bit == 3'd7)) w_next = R_STOP;
      R_STOP:  if (w_full) w_next = R_IDLE;
      default: w_next = R_IDLE;
    endcase
  end

  // Bit timing counter, bit index and LSB-first shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      case (r_state)
        R_START: r_cnt <= w_half ? '0 : r_cnt + CNT_W'(1);
        R_DATA, R_STOP: r_cnt <= w_full ? '0 : r_cnt + CNT_W'(1);
        default: r_cnt <= '0;
      endcase
      if (r_state == R_IDLE) begin
        r_bit <= 3'd0;
      end else if ((r_state == R_DATA) && w_full) begin
        r_bit   <= r_bit + 3'd1;
        r_shift <= {w_rx, r_shift[7:1]};
      end
    end
  end

  // RX outputs decoded at the stop-bit sample point
  always_comb begin
    rx_data    = r_shift;
    byte_valid = (r_state == R_STOP) && w_full && w_rx;
    stop_err   = (r_state == R_STOP) && w_full && !w_rx;
  end

endmodule
`default_nettype wire

// File: rtl/uart_img_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_img_loader                                           |
// | Brief    : Frames received UART bytes into one IMG_PIXELS image and  |
// |            writes it to RAM; pulses start / holds en when complete.  |
// |            Optional macro IMG_HDR_EN: require 55 AA header per frame.|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_img_loader
  import uart_img_pkg::*;
#(
  parameter int CLK_FREQ    = 48_000_000,
  parameter int BAUD        = 115200,
  parameter int IMG_PIXELS  = IMG_PIXELS_DEFAULT,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 4 * (CLK_FREQ / BAUD) * 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              key,
  output logic [7:0]        ram_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  output logic              start,
  output logic              en,
  output logic              busy,
  output logic              frame_err
);

  localparam int BIT_CYC  = CLK_FREQ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int TO_W     = $clog2(TIMEOUT_CYC + 1);

`ifdef IMG_HDR_EN
  localparam frame_state_t F_REST = F_HDR0;
`else
  localparam frame_state_t F_REST = F_IDLE;
`endif

  generate
    if (IMG_PIXELS > (2 ** ADDR_W)) begin : g_addr_check
      $error("uart_img_loader: IMG_PIXELS does not fit in ADDR_W address bits");
    end
  endgenerate

  logic [7:0]        w_rx_data;
  logic              w_byte_valid;
  logic              w_stop_err;
  frame_state_t      r_state;
  frame_state_t      w_next;
  logic [ADDR_W-1:0] r_idx;
  logic [TO_W-1:0]   r_tcnt;
  logic              r_done;
  logic              w_timed;
  logic              w_load_st;
  logic              w_last;
  logic              w_write;
  logic              w_timeout;

  uart_rx_byte #(
    .BIT_CYC  (BIT_CYC),
    .HALF_CYC (HALF_CYC)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (w_rx_data),
    .byte_valid (w_byte_valid),
    .stop_err   (w_stop_err)
  );

  // Qualifiers: which states accept pixels / run the inter-byte timeout
  always_comb begin
`ifdef IMG_HDR_EN
    w_timed   = (r_state == F_LOAD) || (r_state == F_HDR1);
    w_load_st = (r_state == F_LOAD);
`else
    w_timed   = (r_state == F_LOAD);
    w_load_st = (r_state == F_LOAD) || (r_state == F_IDLE);
`endif
    w_last    = (r_idx == ADDR_W'(IMG_PIXELS - 1));
    w_write   = w_byte_valid && !key && w_load_st;
    w_timeout = w_timed && !key && !w_byte_valid && (r_tcnt == TO_W'(TIMEOUT_CYC - 1));
  end

  // Frame state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= F_REST;
    else     r_state <= w_next;
  end

  // Frame next-state: key beats everything, then timeout, then bytes
  always_comb begin
    w_next = r_state;
    if (key || w_timeout) begin
      w_next = F_REST;
    end else if (w_write) begin
      w_next = w_last ? F_REST : F_LOAD;
    end
`ifdef IMG_HDR_EN
    else if (w_byte_valid) begin
      case (r_state)
        F_HDR0:  if (w_rx_data == HDR0) w_next = F_HDR1;
        F_HDR1:  begin
          if (w_rx_data == HDR1)      w_next = F_LOAD;
          else if (w_rx_data == HDR0) w_next = F_HDR1;
          else                        w_next = F_HDR0;
        end
        default: w_next = r_state;
      endcase
    end
`endif
  end

  // Frame outputs decoded from state
  always_comb begin
    busy = (r_state == F_LOAD);
  end

  // Registered RAM write port, pixel index, completion and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en    <= 1'b0;
      ram_addr  <= '0;
      ram_q     <= 8'h00;
      r_idx     <= '0;
      r_done    <= 1'b0;
      start     <= 1'b0;
      en        <= 1'b0;
      frame_err <= 1'b0;
      r_tcnt    <= '0;
    end else begin
      ram_en <= w_write;
      if (w_write) begin
        ram_addr <= r_idx;
        ram_q    <= w_rx_data;
      end
      if (key || w_timeout)  r_idx <= '0;
      else if (w_write)      r_idx <= w_last ? '0 : r_idx + ADDR_W'(1);
      r_done <= w_write && w_last;
      start  <= r_done;
      if (key)                         en <= 1'b0;
      else if (w_write && (r_idx == '0)) en <= 1'b0;
      else if (r_done)                 en <= 1'b1;
      frame_err <= w_stop_err || w_timeout;
      r_tcnt    <= (w_timed && !w_byte_valid && !w_timeout && !key) ? r_tcnt + TO_W'(1) : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_img_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_uart_img_loader                                        |
// | Brief    : Randomized self-checking bench for uart_img_loader with   |
// |            an event-queue reference model. Honours IMG_HDR_EN.       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_uart_img_loader;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int BIT      = CLK_FREQ / BAUD;   // 16
  localparam int HALF     = BIT / 2;           // 8
  localparam int P        = 16;
  localparam int AW       = 4;
  localparam int TO       = 4 * BIT * 10;      // 640

  localparam int EV_WR = 0, EV_START = 1, EV_ERR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic          key = 1'b0;
  logic [7:0]    ram_q;
  logic [AW-1:0] ram_addr;
  logic          ram_en, start, en, busy, frame_err;

  uart_img_loader #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .IMG_PIXELS (P),
    .ADDR_W     (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .key       (key),
    .ram_q     (ram_q),
    .ram_addr  (ram_addr),
    .ram_en    (ram_en),
    .start     (start),
    .en        (en),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int addr; int data; } ev_t;
  ev_t q[$];

  int n_cmp = 0, n_fail = 0;
  int obs_wr = 0, obs_start = 0, obs_err = 0;
  int last_wr_cyc = -100;

  // Reference model: 0 = idle / waiting 55, 1 = waiting AA, 2 = loading
  int m_phase = 0, m_idx = 0, m_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(input int k, input int a, input int d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    q.push_back(e);
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit good, input bit key_hit);
    if (!good) begin
      push(EV_ERR, 0, 0);
      return;
    end
    if (key_hit) begin
      m_phase = 0; m_idx = 0; m_en = 0;
      return;
    end
`ifdef IMG_HDR_EN
    if (m_phase == 0) begin
      if (b == 8'h55) m_phase = 1;
      return;
    end
    if (m_phase == 1) begin
      if (b == 8'hAA)      m_phase = 2;
      else if (b != 8'h55) m_phase = 0;
      return;
    end
`endif
    push(EV_WR, m_idx, int'(b));
    if (m_idx == 0) m_en = 0;
    m_idx++;
    m_phase = 2;
    if (m_idx == P) begin
      push(EV_START, 0, 0);
      m_en = 1; m_idx = 0; m_phase = 0;
    end
  endfunction

  task automatic expect_ev(input int k, input int a, input int d);
    ev_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL event: got kind %0d addr %0d data %0d, expected no event (t=%0t)", k, a, d, $time);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.addr != a || e.data != d) begin
        n_fail++;
        $display("FAIL event: got kind %0d addr %0d data %0d, expected kind %0d addr %0d data %0d (t=%0t)",
                 k, a, d, e.kind, e.addr, e.data, $time);
      end
    end
  endtask

  // Compare every output event against the model queue
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_en) begin
        obs_wr++;
        last_wr_cyc = cyc;
        expect_ev(EV_WR, int'(ram_addr), int'(ram_q));
      end
      if (start) begin
        obs_start++;
        chk("start_after_write", cyc - last_wr_cyc, 1);
        expect_ev(EV_START, 0, 0);
      end
      if (frame_err) begin
        obs_err++;
        expect_ev(EV_ERR, 0, 0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit good, input bit key_hit);
    int n;
    model_byte(b, good, key_hit);
    @(negedge clk);
    n  = cyc;
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = good;
    // Stop-bit sample edge is n+3+HALF+9*BIT; byte_valid is high the cycle before it
    for (int j = 0; j < BIT; j++) begin
      key = key_hit && (cyc == n + 2 + HALF + 9 * BIT);
      @(negedge clk);
    end
    key = 1'b0;
    rx  = 1'b1;
    if (!good) repeat (BIT) @(negedge clk);
    repeat (2 + $urandom_range(0, 12)) @(negedge clk);
    chk("busy", int'(busy), (m_phase == 2) ? 1 : 0);
    chk("en", int'(en), m_en);
  endtask

  task automatic send_hdr();
`ifdef IMG_HDR_EN
    send_byte(8'h55, 1'b1, 1'b0);
    send_byte(8'hAA, 1'b1, 1'b0);
`endif
  endtask

  task automatic idle_timeout();
    if (m_phase != 0) begin
      push(EV_ERR, 0, 0);
      m_phase = 0; m_idx = 0;
    end
    repeat (TO + 40) @(negedge clk);
  endtask

  task automatic pulse_key();
    m_phase = 0; m_idx = 0; m_en = 0;
    @(negedge clk); key = 1'b1;
    @(negedge clk); key = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ram_q"},     int'(ram_q),     0);
    chk({tag, "_ram_addr"},  int'(ram_addr),  0);
    chk({tag, "_ram_en"},    int'(ram_en),    0);
    chk({tag, "_start"},     int'(start),     0);
    chk({tag, "_en"},        int'(en),        0);
    chk({tag, "_busy"},      int'(busy),      0);
    chk({tag, "_frame_err"}, int'(frame_err), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, st0, er0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");

    // 1: full frame, data = idx % 256
    wr0 = obs_wr; st0 = obs_start;
    send_hdr();
    for (int i = 0; i < P; i++) send_byte(8'(i % 256), 1'b1, 1'b0);
    chk("t1_writes", obs_wr - wr0, 16);
    chk("t1_starts", obs_start - st0, 1);
    chk("t1_en", int'(en), 1);
    chk("t1_busy", int'(busy), 0);

    // 2: byte 10 with a bad stop bit, then the same address is reused
    wr0 = obs_wr; st0 = obs_start; er0 = obs_err;
    send_hdr();
    for (int i = 0; i < P; i++) begin
      if (i == 10) send_byte(8'hC3, 1'b0, 1'b0);
      send_byte(8'($urandom), 1'b1, 1'b0);
    end
    chk("t2_writes", obs_wr - wr0, 16);
    chk("t2_errs", obs_err - er0, 1);
    chk("t2_starts", obs_start - st0, 1);

    // 3: short glitch on rx, shorter than half a bit
    wr0 = obs_wr; er0 = obs_err;
    @(negedge clk); rx = 1'b0;
    repeat (4) @(negedge clk); rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    chk("t3_writes", obs_wr - wr0, 0);
    chk("t3_errs", obs_err - er0, 0);

    // 4: partial frame then inter-byte timeout, then a clean frame
    st0 = obs_start; er0 = obs_err;
    send_hdr();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    chk("t4_busy_mid", int'(busy), 1);
    chk("t4_en_mid", int'(en), 0);
    idle_timeout();
    chk("t4_errs", obs_err - er0, 1);
    chk("t4_starts", obs_start - st0, 0);
    chk("t4_busy_after", int'(busy), 0);
    send_hdr();
    for (int i = 0; i < P; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    chk("t4_starts_total", obs_start - st0, 1);

    // 5: standalone key clears en; key coincident with a byte drops it
    pulse_key();
    chk("t5_en_key", int'(en), 0);
    wr0 = obs_wr;
    send_hdr();
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    send_byte(8'h7E, 1'b1, 1'b1);
    chk("t5_busy_abort", int'(busy), 0);
    send_hdr();
    for (int i = 0; i < P; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    chk("t5_writes", obs_wr - wr0, 26);

    // 6: header handling (or raw 0x55 as pixel 0 without the header option)
    wr0 = obs_wr; st0 = obs_start;
`ifdef IMG_HDR_EN
    send_byte(8'h12, 1'b1, 1'b0);
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'h55, 1'b1, 1'b0);
    send_byte(8'h55, 1'b1, 1'b0);
    send_byte(8'hAA, 1'b1, 1'b0);
    chk("t6_busy_hdr", int'(busy), 1);
    for (int i = 0; i < P; i++) send_byte(8'($urandom), 1'b1, 1'b0);
`else
    send_byte(8'h55, 1'b1, 1'b0);
    for (int i = 1; i < P; i++) send_byte(8'($urandom), 1'b1, 1'b0);
`endif
    chk("t6_writes", obs_wr - wr0, 16);
    chk("t6_starts", obs_start - st0, 1);

    // 7: reset in the middle of a byte inside a frame
    send_hdr();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    chk("t7_queue_before_rst", q.size(), 0);
    @(negedge clk); rx = 1'b0;
    repeat (3 * BIT) @(negedge clk); rx = 1'b1;
    repeat (BIT) @(negedge clk); rx = 1'b0;
    rst = 1'b1;
    m_phase = 0; m_idx = 0; m_en = 0;
    repeat (3) @(negedge clk);
    rx  = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    st0 = obs_start;
    send_hdr();
    for (int i = 0; i < P; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    chk("t7_starts", obs_start - st0, 1);

    repeat (20) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
